jtag_chain_sequencer: RTL and testbench

Bit-level JTAG master for the twelve-target JTAG mux. It accepts one scan command at a time: a target select, a length, and TMS/TDI vectors. It generates the TCK waveform from the system clock, drives the mux's select and virtual TMS/TCK/TDI, captures the selected TDO, and returns the captured vector through a one-cycle response strobe. It sits between the register/host interface and the JTAG mux, and is the only driver of the mux's select and virtual JTAG inputs.

---
 rtl/jtag_pkg.sv | 22 ++
 rtl/jtag_chain_sequencer_if.sv | 25 ++
 rtl/jtag_tck_gen.sv | 31 +++
 rtl/jtag_chain_sequencer.sv | 171 +++++++++++++++++
 tb/tb_jtag_chain_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG chain sequencer.
// Optional feature macro: JTAG_SEQ_AUTO_TLR_EN (auto Test-Logic-Reset on select change).
package jtag_pkg;

    localparam int JTAG_NUM_CHAINS = 12;
    localparam int JTAG_MAX_BITS   = 32;
    localparam int JTAG_TLR_CLOCKS = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_TLR,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } jtag_state_t;

    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        return (len > 6'(JTAG_MAX_BITS)) ? 6'(JTAG_MAX_BITS) : len;
    endfunction

endpackage

// File: rtl/jtag_chain_sequencer_if.sv
// Command/response bundle between the host side and the JTAG sequencer.
// The master drives commands; the slave (sequencer) returns the TDO vector.
interface jtag_chain_sequencer_if #(
    parameter int MAX_BITS = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_sel;
    logic [5:0]          cmd_len;
    logic [MAX_BITS-1:0] cmd_tms;
    logic [MAX_BITS-1:0] cmd_tdi;
    logic                rsp_valid;
    logic [MAX_BITS-1:0] rsp_tdo;
    logic                busy;

    modport master (
        output cmd_valid, cmd_sel, cmd_len, cmd_tms, cmd_tdi,
        input  cmd_ready, rsp_valid, rsp_tdo, busy
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_len, cmd_tms, cmd_tdi,
        output cmd_ready, rsp_valid, rsp_tdo, busy
    );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK phase counter: one tick per CLK_DIV enabled cycles, TCK toggles on tick.
// A start pulse restarts the phase with TCK low.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic en,
    output logic tick,
    output logic tck
);
    logic [7:0] cnt;

    assign tick = en && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            tck <= ~tck;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/jtag_chain_sequencer.sv
// Bit-level JTAG master driving the twelve-target mux select and virtual TAP pins.
// Define JTAG_SEQ_AUTO_TLR_EN to insert 5 TMS=1 clocks whenever the target changes.
module jtag_chain_sequencer
    import jtag_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = JTAG_MAX_BITS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    jtag_chain_sequencer_if.slave  bus,
    output logic [3:0]             jtag_sel,
    output logic                   v_tck,
    output logic                   v_tms,
    output logic                   v_tdi,
    input  logic                   v_tdo
);
    localparam int IW = $clog2(MAX_BITS);

    jtag_state_t         state;
    logic [5:0]          len_r;
    logic [5:0]          idx;
    logic [MAX_BITS-1:0] tms_r;
    logic [MAX_BITS-1:0] tdi_r;
    logic [MAX_BITS-1:0] tdo_sh;
    logic                tick;
    logic                start;
    logic                en;
    logic                accept;
    logic                last_bit;

`ifdef JTAG_SEQ_AUTO_TLR_EN
    logic [3:0] last_sel;
    logic       sel_vld;
    logic       need_tlr;
    logic [2:0] tlr_cnt;
`endif

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign start    = (state == ST_SETUP);
    assign en       = (state == ST_TLR) || (state == ST_SHIFT_LO) ||
                      (state == ST_SHIFT_HI);
    assign last_bit = (idx == len_r - 6'd1);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk   (clk),
        .rst_n (reset_n),
        .start (start),
        .en    (en),
        .tick  (tick),
        .tck   (v_tck)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_tdo   <= '0;
            bus.busy      <= 1'b0;
            jtag_sel      <= 4'd0;
            v_tms         <= 1'b1;
            v_tdi         <= 1'b0;
            len_r         <= '0;
            idx           <= '0;
            tms_r         <= '0;
            tdi_r         <= '0;
            tdo_sh        <= '0;
`ifdef JTAG_SEQ_AUTO_TLR_EN
            last_sel      <= 4'd0;
            sel_vld       <= 1'b0;
            need_tlr      <= 1'b0;
            tlr_cnt       <= '0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state         <= ST_SETUP;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        jtag_sel      <= bus.cmd_sel;
                        len_r         <= clamp_len(bus.cmd_len);
                        tms_r         <= bus.cmd_tms;
                        tdi_r         <= bus.cmd_tdi;
                        tdo_sh        <= '0;
                        idx           <= '0;
`ifdef JTAG_SEQ_AUTO_TLR_EN
                        need_tlr      <= !sel_vld || (bus.cmd_sel != last_sel);
                        last_sel      <= bus.cmd_sel;
                        sel_vld       <= 1'b1;
`endif
                    end else begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ST_SETUP: begin
`ifdef JTAG_SEQ_AUTO_TLR_EN
                    if (need_tlr) begin
                        state   <= ST_TLR;
                        v_tms   <= 1'b1;
                        v_tdi   <= 1'b0;
                        tlr_cnt <= '0;
                    end else
`endif
                    if (len_r != 6'd0) begin
                        state <= ST_SHIFT_LO;
                        v_tms <= tms_r[0];
                        v_tdi <= tdi_r[0];
                        tms_r <= tms_r >> 1;
                        tdi_r <= tdi_r >> 1;
                    end else begin
                        state         <= ST_DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.cmd_ready <= 1'b1;
                        bus.rsp_tdo   <= tdo_sh;
                    end
                end
`ifdef JTAG_SEQ_AUTO_TLR_EN
                ST_TLR: begin
                    // Only the end of each high phase counts a completed pulse.
                    if (tick && v_tck) begin
                        if (tlr_cnt == 3'(JTAG_TLR_CLOCKS - 1)) begin
                            if (len_r != 6'd0) begin
                                state <= ST_SHIFT_LO;
                                v_tms <= tms_r[0];
                                v_tdi <= tdi_r[0];
                                tms_r <= tms_r >> 1;
                                tdi_r <= tdi_r >> 1;
                            end else begin
                                state         <= ST_DONE;
                                bus.rsp_valid <= 1'b1;
                                bus.cmd_ready <= 1'b1;
                                bus.rsp_tdo   <= tdo_sh;
                            end
                        end else begin
                            tlr_cnt <= tlr_cnt + 3'd1;
                        end
                    end
                end
`endif
                ST_SHIFT_LO: begin
                    if (tick) begin
                        state               <= ST_SHIFT_HI;
                        tdo_sh[idx[IW-1:0]] <= v_tdo;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        if (last_bit) begin
                            state         <= ST_DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.cmd_ready <= 1'b1;
                            bus.rsp_tdo   <= tdo_sh;
                        end else begin
                            state <= ST_SHIFT_LO;
                            idx   <= idx + 6'd1;
                            v_tms <= tms_r[0];
                            v_tdi <= tdi_r[0];
                            tms_r <= tms_r >> 1;
                            tdi_r <= tdi_r >> 1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_chain_sequencer.sv
// Scoreboard bench: unit 0 runs with CLK_DIV=2, unit 1 with CLK_DIV=1.
// Expected TDO, response cycle and pulse counts are queued at issue time.
module tb_jtag_chain_sequencer;
    import jtag_pkg::*;

    typedef struct {
        int          unit;
        logic [3:0]  sel;
        logic [31:0] tdo;
        int          cyc;
        int          np;
        int          nt;
        int          bp;
        int          bt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n [2];
    logic        c_valid [2];
    logic [3:0]  c_sel [2];
    logic [5:0]  c_len [2];
    logic [31:0] c_tms [2];
    logic [31:0] c_tdi [2];
    bit          tdo_mode [2];

    logic        rdy [2];
    logic        rv [2];
    logic        bsy [2];
    logic        tck [2];
    logic        tms [2];
    logic        tdi [2];
    logic [31:0] tdo [2];
    logic [3:0]  sel [2];

    int   pulses [2] = '{0, 0};
    int   tms1 [2] = '{0, 0};
    int   cmd_base [2] = '{0, 0};
    int   last_rise [2] = '{0, 0};
    logic tck_q [2] = '{1'b0, 1'b0};
    bit   last_vld [2] = '{1'b0, 1'b0};
    logic [3:0] last_s [2];

    for (genvar g = 0; g < 2; g++) begin : u
        jtag_chain_sequencer_if #(.MAX_BITS(32)) bus ();
        logic v_tdo;
        assign bus.cmd_valid = c_valid[g];
        assign bus.cmd_sel   = c_sel[g];
        assign bus.cmd_len   = c_len[g];
        assign bus.cmd_tms   = c_tms[g];
        assign bus.cmd_tdi   = c_tdi[g];
        assign rdy[g] = bus.cmd_ready;
        assign rv[g]  = bus.rsp_valid;
        assign bsy[g] = bus.busy;
        assign tdo[g] = bus.rsp_tdo;
        assign v_tdo  = tdo_mode[g] ? 1'b1 : tdi[g];
        jtag_chain_sequencer #(
            .CLK_DIV  (g == 0 ? 2 : 1),
            .MAX_BITS (32)
        ) dut (
            .clk      (clk),
            .reset_n  (rst_n[g]),
            .bus      (bus),
            .jtag_sel (sel[g]),
            .v_tck    (tck[g]),
            .v_tms    (tms[g]),
            .v_tdi    (tdi[g]),
            .v_tdo    (v_tdo)
        );
    end

    function automatic int dv(int g);
        return (g == 0) ? 2 : 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (tck[g] && !tck_q[g]) begin
                if (bsy[g] && pulses[g] > cmd_base[g])
                    check($sformatf("tck_period_u%0d", g), cyc - last_rise[g], 2 * dv(g));
                pulses[g]++;
                if (tms[g]) tms1[g]++;
                last_rise[g] = cyc;
            end
            tck_q[g] = tck[g];
            if (rv[g]) begin
                if (sb.size() == 0 || sb[0].unit != g) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp unit=%0d cycle=%0d", g, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("rsp_tdo_u%0d", g), tdo[g], mon_e.tdo);
                    check($sformatf("rsp_cycle_u%0d", g), cyc, mon_e.cyc);
                    check($sformatf("pulses_u%0d", g), pulses[g] - mon_e.bp, mon_e.np);
                    check($sformatf("tms1_u%0d", g), tms1[g] - mon_e.bt, mon_e.nt);
                    check($sformatf("jtag_sel_u%0d", g), sel[g], mon_e.sel);
                    check($sformatf("busy_at_rsp_u%0d", g), bsy[g], 1);
                    check($sformatf("ready_at_rsp_u%0d", g), rdy[g], 1);
                end
            end
        end
    end

    task automatic send(int g, logic [3:0] s, logic [5:0] len,
                        logic [31:0] tm, logic [31:0] ti,
                        logic [31:0] ex, bit expect_rsp);
        int lc;
        int t;
        int w;
        logic [31:0] m;
        exp_t e;
        lc = (len > 6'd32) ? 32 : int'(len);
        m = (lc == 32) ? 32'hFFFF_FFFF : ((32'd1 << lc) - 32'd1);
        t = 0;
`ifdef JTAG_SEQ_AUTO_TLR_EN
        if (!last_vld[g] || s != last_s[g]) t = JTAG_TLR_CLOCKS;
        last_vld[g] = 1'b1;
        last_s[g] = s;
`endif
        w = 0;
        while (!rdy[g] && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[g]) begin
            checks++;
            failures++;
            $display("FAIL cmd_ready_timeout unit=%0d", g);
            return;
        end
        c_valid[g] = 1'b1;
        c_sel[g] = s;
        c_len[g] = len;
        c_tms[g] = tm;
        c_tdi[g] = ti;
        if (expect_rsp) begin
            e.unit = g;
            e.sel = s;
            e.tdo = ex;
            e.cyc = cyc + 2 + 2 * dv(g) * (lc + t);
            e.np = lc + t;
            e.nt = t + $countones(tm & m);
            e.bp = pulses[g];
            e.bt = tms1[g];
            sb.push_back(e);
        end
        cmd_base[g] = pulses[g];
        @(negedge clk);
        c_valid[g] = 1'b0;
        c_sel[g] = 4'hE;
        c_len[g] = 6'd1;
        c_tms[g] = '1;
        c_tdi[g] = '1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb.size() != 0 || !rdy[0] || !rdy[1]) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || !rdy[0] || !rdy[1]) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout pending=%0d", sb.size());
        end
    endtask

    initial begin
        int w;
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0;
            c_valid[g] = 1'b0;
            c_sel[g] = '0;
            c_len[g] = '0;
            c_tms[g] = '0;
            c_tdi[g] = '0;
            tdo_mode[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_ready_u%0d", g), rdy[g], 1);
            check($sformatf("rst_rsp_valid_u%0d", g), rv[g], 0);
            check($sformatf("rst_rsp_tdo_u%0d", g), tdo[g], 0);
            check($sformatf("rst_busy_u%0d", g), bsy[g], 0);
            check($sformatf("rst_sel_u%0d", g), sel[g], 0);
            check($sformatf("rst_tck_u%0d", g), tck[g], 0);
            check($sformatf("rst_tms_u%0d", g), tms[g], 1);
            check($sformatf("rst_tdi_u%0d", g), tdi[g], 0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("ready_after_reset_u0", rdy[0], 1);
        check("ready_after_reset_u1", rdy[1], 1);

        send(0, 4'd3, 6'd8, 32'h0, 32'hA5, 32'h0000_00A5, 1'b1);
        @(negedge clk);
        check("busy_mid_cmd", bsy[0], 1);
        check("ready_mid_cmd", rdy[0], 0);
        wait_idle();
        repeat (4) @(negedge clk);
        check("hold_rsp_tdo", tdo[0], 32'h0000_00A5);
        check("idle_tck", tck[0], 0);
        check("idle_tms_hold", tms[0], 0);
        check("idle_tdi_hold", tdi[0], 1);
        check("idle_sel_hold", sel[0], 3);
        check("idle_busy", bsy[0], 0);

        tdo_mode[0] = 1'b1;
        send(0, 4'd3, 6'd32, 32'h8000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        send(0, 4'd3, 6'd40, 32'h8000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        tdo_mode[0] = 1'b0;
        send(0, 4'd7, 6'd8, 32'h0, 32'h3C, 32'h0, 1'b0);
        w = 0;
        while (pulses[0] - cmd_base[0] < 3 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("third_rise_seen", (pulses[0] - cmd_base[0] >= 3) ? 1 : 0, 1);
        rst_n[0] = 1'b0;
        #1;
        check("midrst_tck", tck[0], 0);
        check("midrst_tms", tms[0], 1);
        check("midrst_busy", bsy[0], 0);
        check("midrst_ready", rdy[0], 1);
        check("midrst_rsp_tdo", tdo[0], 0);
        check("midrst_sel", sel[0], 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        last_vld[0] = 1'b0;
        repeat (40) @(negedge clk);
        send(0, 4'd2, 6'd4, 32'h0, 32'h9, 32'h9, 1'b1);
        wait_idle();
        send(0, 4'd2, 6'd0, 32'h0, 32'hF, 32'h0, 1'b1);
        wait_idle();

        send(1, 4'd3, 6'd4, 32'h0, 32'h6, 32'h6, 1'b1);
        send(1, 4'd3, 6'd4, 32'h0, 32'hA, 32'hA, 1'b1);
        send(1, 4'd5, 6'd4, 32'h0, 32'h3, 32'h3, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
